// File: rtl/handshake_arbiter_pkg.sv
// Shared types and constants for the two-port round-robin handshake arbiter.
package handshake_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  localparam int DEF_DATA_WIDTH = 4;

endpackage

// File: rtl/handshake_arbiter_rr_pick2.sv
// Combinational two-way round-robin select; one-hot grant from the request pair.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] gnt
);

  // On contention the port that was not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_served ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/handshake_arbiter.sv
// Two-port round-robin arbiter in front of one request/confirm target, four-phase release.
// Optional REQ watchdog compiled in with `define HANDSHAKE_ARB_TIMEOUT_EN.
module handshake_arbiter
  import handshake_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request_0,
  input  logic                  request_1,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  output logic [1:0]            grant,
  output logic                  done_0,
  output logic                  done_1,
  output logic                  bus_request,
  output logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  confirm,
  output logic                  timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            done_q, done_d;
  logic                  breq_q, breq_d;
  logic [DATA_WIDTH-1:0] bdata_q, bdata_d;
  logic                  timeout_q, timeout_d;
  logic                  last_q, last_d;
  logic [1:0]            pick;
  logic                  owner, owner_req;

`ifdef HANDSHAKE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick2 u_pick (
    .req         ({request_1, request_0}),
    .last_served (last_q),
    .gnt         (pick)
  );

  assign owner     = grant_q[PORT1];
  assign owner_req = owner ? request_1 : request_0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = 2'b00;
    breq_d    = breq_q;
    bdata_d   = bdata_q;
    timeout_d = 1'b0;
    last_d    = last_q;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          grant_d = pick;
          bdata_d = pick[PORT1] ? data_in_1 : data_in_0;
          breq_d  = 1'b1;
          state_d = ST_REQ;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        // Confirm outranks both withdraw and timeout.
        if (confirm) begin
          done_d  = grant_q;
          last_d  = owner;
          breq_d  = 1'b0;
          state_d = ST_HOLD;
        end else if (!owner_req) begin
          grant_d = 2'b00;
          breq_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            last_d    = owner;
            breq_d    = 1'b0;
            state_d   = ST_HOLD;
          end
`endif
        end
      end
      ST_HOLD: begin
        if (!owner_req && !confirm) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        breq_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      breq_q    <= 1'b0;
      bdata_q   <= '0;
      timeout_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      breq_q    <= breq_d;
      bdata_q   <= bdata_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

`ifdef HANDSHAKE_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign done_0      = done_q[PORT0];
  assign done_1      = done_q[PORT1];
  assign bus_request = breq_q;
  assign bus_data    = bdata_q;

endmodule
